smg_frame_ctrl: RTL
===================

# smg_frame_ctrl

Sequencing controller for the six-digit seven-segment display. It accepts a binary value from the SPI receive path over a valid/ready handshake and converts it to six BCD digits with a sequential double-dabble. It applies leading-zero blanking and commits the result to the digit-nibble bus only at a scan-frame boundary, so a displayed frame never mixes old and new digits. It also owns the 1 ms digit-scan timing and drives the active-low digit enables.

## Interface
- T1MS, 16'd49999 — last count of the 1 ms slot counter (50 MHz CLK).
- BLANK_LZ, 1 — 1: leading zeros shown as blank nibble 4'hF; 0: zeros shown.
- CLK  in  1  system clock, all logic on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Bin_Data  in  20  unsigned value to display.
- Bin_Valid  in  1  Bin_Data valid; source holds data until accepted.
- Bin_Ready  out  1  controller can accept; transfer when Bin_Valid && Bin_Ready.
- Number_Sig  out  24  six BCD nibbles; [23:20] is the hundred-thousands digit, [3:0] the units digit.
- Scan_Sig  out  6  one-hot active-low digit enable; bit 5 is the hundred-thousands digit.
- Ovf  out  1  last committed value was saturated.
- Busy  out  1  conversion or commit pending.

## Operation
- Scan counter C1 counts 0..T1MS and wraps. Digit index D counts 0..5 and advances when C1==T1MS; 5 wraps to 0.
- Scan_Sig = ~(6'b100000 >> D).
- Frame end (FE) is the cycle with D==5 && C1==T1MS.
- FSM states: IDLE, CONV, BLANK, WAIT_FRAME.
- IDLE: Bin_Ready=1.
  - On transfer: if Bin_Data > 999999, load 999999 and set ovf_pend=1; else load Bin_Data and set ovf_pend=0.
  - Clear the 44-bit shift register {bcd[23:0], bin[19:0]} and the iteration counter. Go to CONV.
- CONV: 20 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts the whole register left by 1. After iteration 20, go to BLANK.
- BLANK, one cycle: if BLANK_LZ, replace each leading zero nibble with 4'hF, scanning from [23:20] down. Digit [3:0] is never blanked. Go to WAIT_FRAME.
- WAIT_FRAME: on FE, register Number_Sig ← staged digits and Ovf ← ovf_pend, then go to IDLE.
- Bin_Ready=0 and Busy=1 in CONV, BLANK and WAIT_FRAME.
- Boundary rules:
  - FE occurring in CONV or BLANK is ignored; the commit waits for the next FE seen in WAIT_FRAME.
  - Bin_Valid while not ready: the source holds, nothing is dropped or queued. There is no input buffering beyond one value.
  - Value 0 commits 24'hFFFFF0 with BLANK_LZ=1, 24'h000000 with BLANK_LZ=0.
  - Ovf is sticky only until the next commit.
- Reset mid-operation: the FSM returns to IDLE and any pending value is discarded.

## Timing
- Reset values:
  - C1=0, D=0, Scan_Sig=6'b011111.
  - Number_Sig=24'hFFFFF0 if BLANK_LZ, else 24'h000000.
  - Ovf=0, Busy=0, Bin_Ready=1.
- Transfer in cycle t. CONV occupies t+1..t+20, BLANK is t+21, WAIT_FRAME starts at t+22.
- Number_Sig and Ovf change in the cycle after the first FE at or after t+22.
- Worst-case latency to display: 22 + 6·(T1MS+1) cycles.
- Bin_Ready rises in the cycle after commit. The next transfer can occur in that cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package smg_pkg holds:
  - T1MS default.
  - NUM_DIGITS=6.
  - MAX_VAL=20'd999999.
  - BLANK_NIB=4'hF.
  - Iteration count 20.
  - FSM state encoding.
- Sub-module bin2bcd_seq holds the double-dabble datapath (load, step, done; 20-bit in, 24-bit out).
- The top module holds the scan counter, the handshake/FSM, blanking and the commit register.

## Test plan
Sim uses T1MS=9, so a frame is 60 cycles.
- Reset, then idle → Number_Sig=24'hFFFFF0, Scan_Sig cycles through 011111, 101111, …, 111110, advancing every 10 cycles; Bin_Ready=1.
- Send 20'd123456 → Bin_Ready low for at least 22 cycles; Number_Sig=24'h123456 exactly one cycle after the next FE; Ovf=0.
- Send 20'd907 with BLANK_LZ=1 → 24'hFFF907; with BLANK_LZ=0 → 24'h000907.
- Send 20'hFFFFF (1048575) → Number_Sig=24'h999999, Ovf=1. Then send 20'd5 → 24'hFFFFF5, Ovf=0.
- Transfer timed so CONV spans an FE → no commit at that FE; commit at the following FE. Number_Sig never changes except one cycle after an FE.
- Assert RSTn low during WAIT_FRAME → outputs return to reset values, the pending value is never displayed, and Bin_Ready=1 after release.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants, FSM encoding and the leading-zero blanking helper for
// the seven-segment frame controller.
package smg_pkg;

    localparam logic [15:0] T1MS_DEFAULT = 16'd49999;
    localparam int          NUM_DIGITS   = 6;
    localparam int          BIN_W        = 20;
    localparam int          BCD_W        = 4 * NUM_DIGITS;
    localparam int          ITERS        = 20;
    localparam logic [19:0] MAX_VAL      = 20'd999999;
    localparam logic [3:0]  BLANK_NIB    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_BLANK,
        ST_WAIT_FRAME
    } frame_state_e;

    // Blank zero nibbles from the most significant digit down until the first
    // non-zero one; the units digit is always kept so a value of 0 shows "0".
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] digits);
        logic [BCD_W-1:0] result;
        logic             leading;
        result  = digits;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && (digits[i*4 +: 4] == 4'd0)) begin
                result[i*4 +: 4] = BLANK_NIB;
            end else begin
                leading = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per step, 20 steps
// turn a 20-bit binary value into six BCD nibbles.
module bin2bcd_seq
    import smg_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             load,
    input  logic             step,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             done
);

    localparam logic [4:0] ITER_END  = 5'(ITERS);
    localparam logic [4:0] ITER_LAST = 5'(ITERS - 1);

    logic [BCD_W+BIN_W-1:0] shift_reg;
    logic [4:0]             iter;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    always_comb begin
        bcd_adj = shift_reg[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_adj[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj[BCD_W-2:0], shift_reg[BIN_W-1:0], 1'b0};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shift_reg <= '0;
            iter      <= '0;
        end else if (load) begin
            shift_reg <= {{BCD_W{1'b0}}, bin_in};
            iter      <= '0;
        end else if (step && (iter != ITER_END)) begin
            shift_reg <= shifted;
            iter      <= iter + 5'd1;
        end
    end

    // High during the step whose edge completes the conversion.
    assign done    = step && (iter == ITER_LAST);
    assign bcd_out = shift_reg[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/smg_frame_ctrl.sv
// Six-digit display sequencer: 1 ms digit scan, valid/ready intake, BCD
// conversion and frame-aligned commit of the digit nibbles.
module smg_frame_ctrl
    import smg_pkg::*;
#(
    parameter logic [15:0] T1MS     = T1MS_DEFAULT,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [19:0] Bin_Data,
    input  logic        Bin_Valid,
    output logic        Bin_Ready,
    output logic [23:0] Number_Sig,
    output logic [5:0]  Scan_Sig,
    output logic        Ovf,
    output logic        Busy
);

    localparam logic [23:0] NUM_RESET = BLANK_LZ ? {{5{BLANK_NIB}}, 4'd0} : 24'd0;

    logic [15:0]      c1;
    logic [2:0]       d;
    logic [2:0]       d_next;
    logic             frame_end;
    frame_state_e     state;
    logic [BCD_W-1:0] staged;
    logic             ovf_pend;
    logic             transfer;
    logic [19:0]      load_val;
    logic [BCD_W-1:0] bcd;
    logic             conv_done;

    assign d_next    = (d == 3'd5) ? 3'd0 : d + 3'd1;
    assign frame_end = (d == 3'd5) && (c1 == T1MS);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            c1       <= '0;
            d        <= '0;
            Scan_Sig <= 6'b011111;
        end else if (c1 == T1MS) begin
            c1       <= '0;
            d        <= d_next;
            Scan_Sig <= ~(6'b100000 >> d_next);
        end else begin
            c1 <= c1 + 16'd1;
        end
    end

    assign transfer = Bin_Valid && Bin_Ready;
    assign load_val = (Bin_Data > MAX_VAL) ? MAX_VAL : Bin_Data;

    bin2bcd_seq u_bin2bcd (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .load   (transfer),
        .step   (state == ST_CONV),
        .bin_in (load_val),
        .bcd_out(bcd),
        .done   (conv_done)
    );

    // Frame ends seen before WAIT_FRAME are ignored, so a commit always
    // lands on a clean frame boundary with the fully converted value.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            Bin_Ready  <= 1'b1;
            Busy       <= 1'b0;
            Number_Sig <= NUM_RESET;
            Ovf        <= 1'b0;
            staged     <= '0;
            ovf_pend   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        ovf_pend  <= (Bin_Data > MAX_VAL);
                        Bin_Ready <= 1'b0;
                        Busy      <= 1'b1;
                        state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    staged <= BLANK_LZ ? blank_leading(bcd) : bcd;
                    state  <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (frame_end) begin
                        Number_Sig <= staged;
                        Ovf        <= ovf_pend;
                        Bin_Ready  <= 1'b1;
                        Busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
